seq_detection_param: RTL
========================

# seq_detection_param

Parametrised serial pattern detector: it watches a 1-bit stream qualified by `data_valid` and flags every occurrence of a runtime-programmable pattern of 1..`PAT_W` bits. Overlapping or non-overlapping matching is selected at runtime. The registered (Moore-style) match pulse is paired with a saturating match counter. It is the generic successor to the fixed 4-bit cover/noncover detectors and sits directly on serial data lanes ahead of framing logic.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: match counter width.
- `DEF_PAT`, 8'b0000_1011: pattern loaded at reset (LSB-aligned).
- `DEF_LEN`, 4: pattern length loaded at reset.
- `DEF_OVERLAP`, 1: overlap mode loaded at reset.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cfg_load` in 1: latch `cfg_pattern`/`cfg_len`/`cfg_overlap` this cycle.
- `cfg_pattern` in `PAT_W`: pattern, LSB-aligned; bit `len-1` is the first-received bit.
- `cfg_len` in $clog2(PAT_W+1): pattern length.
- `cfg_overlap` in 1: 1 = overlapping matches allowed, 0 = non-overlapping.
- `data_valid` in 1: `data` is a stream bit this cycle.
- `data` in 1: serial stream bit.
- `cnt_clr` in 1: clear match counter.
- `result` out 1: one-cycle match pulse, registered.
- `match_cnt` out `CNT_W`: saturating count of matches.

## Operation
- Internal state: `hist` (`PAT_W` shift reg), `fill` (number of valid history bits, 0..len), active `pat`/`len`/`ovl` registers.
- Reset: `pat`=DEF_PAT, `len`=DEF_LEN, `ovl`=DEF_OVERLAP, `hist`=0, `fill`=0, `result`=0, `match_cnt`=0.
- `cfg_len` clamp on load: 0 → 1; >`PAT_W` → `PAT_W`. Pattern bits above `len` are ignored.
- `cfg_load`=1: load config, clear `hist`/`fill`/`result`. `data` that cycle is discarded. `match_cnt` is kept.
- `data_valid`=1 (no load):
  - `hist_n` = {hist[PAT_W-2:0], data}; `fill_n` = min(fill+1, len).
  - `match` = (fill+1 ≥ len) && hist_n[len-1:0] == pat[len-1:0].
  - On match with `ovl`=0: `fill` ← 0, so the next match needs `len` fresh bits. With `ovl`=1: `fill` stays saturated.
- `data_valid`=0: `hist`/`fill` hold; `result` ← 0.
- `result` ← `match` every cycle. It is never high for two consecutive cycles unless consecutive valid bits each complete a match (possible with `ovl`=1, e.g. all-ones pattern).
- Counter:
  - `match_cnt` increments on match and saturates at 2^CNT_W−1.
  - `cnt_clr` with no match → 0.
  - `cnt_clr` coinciding with match → 1.
- Priority: `rst` > `cfg_load` > `data_valid`. `cnt_clr` is independent of `cfg_load`.

## Timing
- Latency:
  - Final pattern bit sampled at edge k → `result`=1 from edge k to edge k+1.
  - `match_cnt` updates at edge k.
- Throughput: one bit per cycle; back-to-back `data_valid` is supported.
- New config takes effect for bits sampled at the edge after the `cfg_load` edge.
- Reset mid-stream clears partial matches. No match can be reported on the first `len`−1 valid bits after reset or a load.
- `len`=1: every valid bit equal to pat[0] matches, in both modes.

## Test plan
- Defaults (1011, len 4, overlap): after reset, valid stream 1,0,1,0,1,1,1 → `result` pulses once, the cycle after the 6th bit; `match_cnt`=1.
- Load 101/len 3/overlap=1, stream 1,0,1,0,1 → pulses after bits 3 and 5, `match_cnt`=2. Same with overlap=0 → pulse after bit 3 only, `match_cnt`=1.
- Gaps: pattern 1011 with `data_valid` low for 3 cycles between bits 2 and 3 → one match, and `result` stays 0 during the gap.
- Load 1111_1111/len 8/overlap=1, ten valid 1s → pulses after bits 8, 9 and 10. With `cfg_len`=0 loaded and pattern bit0=1, valid 1,0,1 → 2 matches.
- CNT_W=2: 5 matches → `match_cnt` saturates at 3. `cnt_clr` on a match cycle → 1.
- `rst` asserted after 3 bits of 1011, then bit 1 → no match. Also `cfg_load` mid-pattern → history discarded, no match.

Source files
------------

// File: rtl/seq_detection_param.sv
// Runtime-programmable serial pattern detector with overlap select,
// registered match pulse and saturating match counter.
module seq_detection_param #(
  parameter int               PAT_W       = 8,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PAT     = PAT_W'(8'b0000_1011),
  parameter int               DEF_LEN     = 4,
  parameter bit               DEF_OVERLAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         data_valid,
  input  logic                         data,
  input  logic                         cnt_clr,
  output logic                         result,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int LW = $clog2(PAT_W+1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_sh;
  logic [PAT_W-1:0] pat_q, pat_d, mask;
  logic [LW-1:0]    fill_q, fill_d;
  logic [LW-1:0]    len_q, len_d, len_clamp;
  logic             ovl_q, ovl_d;
  logic             result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LW:0]      fill_inc;
  logic             match;

  always_comb begin
    len_clamp = cfg_len;
    if (cfg_len == '0)
      len_clamp = LW'(1);
    else if (cfg_len > LW'(PAT_W))
      len_clamp = LW'(PAT_W);
  end

  // Only the low len bits of history/pattern take part in a compare.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = ((LW+1)'(i) < {1'b0, len_q});
  end

  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    match    = 1'b0;
    fill_inc = {1'b0, fill_q} + (LW+1)'(1);
    hist_sh  = {hist_q[PAT_W-2:0], data};
    if (cfg_load) begin
      pat_d  = cfg_pattern;
      len_d  = len_clamp;
      ovl_d  = cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (data_valid) begin
      match  = (fill_inc >= {1'b0, len_q}) &&
               (((hist_sh ^ pat_q) & mask) == '0);
      hist_d = hist_sh;
      if (match && !ovl_q)
        fill_d = '0;
      else if (fill_inc > {1'b0, len_q})
        fill_d = len_q;
      else
        fill_d = fill_inc[LW-1:0];
    end
    result_d = match;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (match) begin
      if (cnt_clr)
        cnt_d = CNT_W'(1);
      else if (cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
    end else if (cnt_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '0;
      fill_q   <= '0;
      pat_q    <= DEF_PAT;
      len_q    <= LW'(DEF_LEN);
      ovl_q    <= DEF_OVERLAP;
      result_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      pat_q    <= pat_d;
      len_q    <= len_d;
      ovl_q    <= ovl_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result    = result_q;
  assign match_cnt = cnt_q;

endmodule
